// File: rtl/imem_loader.sv
// Byte-stream boot loader driving the CPU instruction-memory initialization port.
// Optional per-frame checksum byte and sticky error state: define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int WRITE_HOLD = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              initialize,
  output logic [ADDR_W-1:0] instruction_initialize_address,
  output logic [31:0]       instruction_initialize_data,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error
);

  localparam int                HOLD_W    = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(WRITE_HOLD - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_ADDR, HDR_CNT, DATA, WRITE, RUN, CSUM, ERR} state_t;
`else
  typedef enum logic [2:0] {HDR_ADDR, HDR_CNT, DATA, WRITE, RUN} state_t;
`endif

  state_t              r_state;
  state_t              w_nextState;
  logic                r_live;
  logic [1:0]          r_byteIdx;
  logic [ADDR_W-1:0]   r_addrShadow;
  logic [15:0]         r_wordsLeft;
  logic [23:0]         r_wordShadow;
  logic [HOLD_W-1:0]   r_holdCnt;
  logic [ADDR_W-1:0]   r_addrOut;
  logic [31:0]         r_dataOut;

  logic                w_accept;
  logic                w_fire;
  logic                w_holdDone;
  logic [15:0]         w_cntIn;
  logic [ADDR_W-1:0]   w_addrShift;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_endFrame;
  logic [7:0]          w_sumNext;

  assign w_accept  = (r_state == HDR_ADDR) || (r_state == HDR_CNT) ||
                     (r_state == DATA) || (r_state == CSUM);
  assign w_sumNext = r_sum + in_data;
`else
  assign w_accept  = (r_state == HDR_ADDR) || (r_state == HDR_CNT) ||
                     (r_state == DATA);
`endif

  // r_live keeps in_ready low while reset is asserted even though HDR_ADDR accepts.
  assign in_ready    = r_live & w_accept;
  assign w_fire      = in_valid & in_ready;
  assign w_cntIn     = {r_wordsLeft[7:0], in_data};
  assign w_addrShift = (r_addrShadow << 8) | ADDR_W'(in_data);
  assign w_holdDone  = (r_state == WRITE) && (r_holdCnt == '0);

  assign instruction_initialize_address = r_addrOut;
  assign instruction_initialize_data    = r_dataOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HDR_ADDR;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    initialize  = 1'b1;
    cpu_rst     = 1'b1;
    load_done   = 1'b0;
    load_error  = 1'b0;
    case (r_state)
      HDR_ADDR: begin
        if (w_fire && (r_byteIdx == 2'd3)) begin
          w_nextState = HDR_CNT;
        end
      end
      HDR_CNT: begin
        if (w_fire && (r_byteIdx == 2'd1)) begin
          if (w_cntIn != 16'd0) begin
            w_nextState = DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            w_nextState = CSUM;
`else
            w_nextState = RUN;
`endif
          end
        end
      end
      DATA: begin
        if (w_fire && (r_byteIdx == 2'd3)) begin
          w_nextState = WRITE;
        end
      end
      WRITE: begin
        if (w_holdDone) begin
          if (r_wordsLeft != 16'd1) begin
            w_nextState = DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            w_nextState = CSUM;
`else
            w_nextState = HDR_ADDR;
`endif
          end
        end
      end
      RUN: begin
        initialize = 1'b0;
        cpu_rst    = 1'b0;
        load_done  = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_fire) begin
          if (w_sumNext != 8'h00) begin
            w_nextState = ERR;
          end else if (r_endFrame) begin
            w_nextState = RUN;
          end else begin
            w_nextState = HDR_ADDR;
          end
        end
      end
      ERR: begin
        load_error = 1'b1;
      end
`endif
      default: begin
        w_nextState = HDR_ADDR;
      end
    endcase
  end

  // Byte assembly and write sequencing; the address/data pair only moves on the DATA->WRITE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live       <= 1'b0;
      r_byteIdx    <= 2'd0;
      r_addrShadow <= '0;
      r_wordsLeft  <= 16'd0;
      r_wordShadow <= 24'd0;
      r_holdCnt    <= '0;
      r_addrOut    <= '0;
      r_dataOut    <= 32'd0;
    end else begin
      r_live <= 1'b1;
      if (w_fire) begin
        case (r_state)
          HDR_ADDR: begin
            r_addrShadow <= (r_byteIdx == 2'd3) ? (w_addrShift & ~ADDR_W'(3)) : w_addrShift;
            r_byteIdx    <= r_byteIdx + 2'd1;
          end
          HDR_CNT: begin
            r_wordsLeft <= w_cntIn;
            r_byteIdx   <= (r_byteIdx == 2'd1) ? 2'd0 : (r_byteIdx + 2'd1);
          end
          DATA: begin
            r_wordShadow <= {r_wordShadow[15:0], in_data};
            r_byteIdx    <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              r_addrOut <= r_addrShadow;
              r_dataOut <= {r_wordShadow, in_data};
              r_holdCnt <= HOLD_LOAD;
            end
          end
          default: begin
          end
        endcase
      end
      if (r_state == WRITE) begin
        if (r_holdCnt == '0) begin
          r_addrShadow <= r_addrShadow + ADDR_W'(4);
          r_wordsLeft  <= r_wordsLeft - 16'd1;
        end else begin
          r_holdCnt <= r_holdCnt - HOLD_W'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum restarts on the first address byte so each frame is checked on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= 8'h00;
      r_endFrame <= 1'b0;
    end else if (w_fire) begin
      if ((r_state == HDR_ADDR) && (r_byteIdx == 2'd0)) begin
        r_sum <= in_data;
      end else begin
        r_sum <= w_sumNext;
      end
      if ((r_state == HDR_CNT) && (r_byteIdx == 2'd1)) begin
        r_endFrame <= (w_cntIn == 16'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a negedge monitor checks them.
// Checksum frames and the bad-checksum case are exercised when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int WRITE_HOLD = 3;
  localparam int ADDR_W     = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              initialize;
  logic [ADDR_W-1:0] instruction_initialize_address;
  logic [31:0]       instruction_initialize_data;
  logic              cpu_rst;
  logic              load_done;
  logic              load_error;

  imem_loader #(
    .WRITE_HOLD(WRITE_HOLD),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .initialize(initialize),
    .instruction_initialize_address(instruction_initialize_address),
    .instruction_initialize_data(instruction_initialize_data),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  exp_t        curExp;
  logic [31:0] wordBuf[8];
  int          compared   = 0;
  int          mismatched = 0;
  bit          prevReady  = 1'b0;
  bit          inHold     = 1'b0;
  int          holdLen    = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // A write starts when in_ready falls while still initializing; it must last WRITE_HOLD cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevReady = 1'b0;
      inHold    = 1'b0;
    end else begin
      if (inHold) begin
        if (in_ready || !initialize || load_error) begin
          checkOutput("holdLength", 64'(holdLen), 64'(WRITE_HOLD));
          inHold = 1'b0;
        end else begin
          holdLen++;
          checkOutput("holdAddrStable", 64'(instruction_initialize_address), 64'(curExp.addr));
          checkOutput("holdDataStable", 64'(instruction_initialize_data), 64'(curExp.data));
        end
      end
      if (!inHold && prevReady && !in_ready && initialize && !load_error) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, required no write",
                   instruction_initialize_address, instruction_initialize_data);
        end else begin
          curExp = expQ.pop_front();
          checkOutput("writeAddr", 64'(instruction_initialize_address), 64'(curExp.addr));
          checkOutput("writeData", 64'(instruction_initialize_data), 64'(curExp.data));
        end
        inHold  = 1'b1;
        holdLen = 1;
      end
      prevReady = in_ready;
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL readyTimeout: in_ready got 0, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Sends one frame built from wordBuf and queues the expected writes.
  task automatic applyStimulus(input logic [31:0] addr, input int n, input int gap, input bit badCsum);
    logic [7:0]  hdr[6];
    logic [7:0]  sum = 8'h00;
    logic [15:0] cnt;
    logic [31:0] runAddr;
    logic [31:0] w;
    logic [7:0]  b;
    exp_t        e;
    cnt    = n[15:0];
    hdr[0] = addr[31:24];
    hdr[1] = addr[23:16];
    hdr[2] = addr[15:8];
    hdr[3] = addr[7:0];
    hdr[4] = cnt[15:8];
    hdr[5] = cnt[7:0];
    for (int i = 0; i < 6; i++) begin
      sum = sum + hdr[i];
`ifndef LOADER_CHECKSUM_EN
      if (n == 0 && i == 5) checkOutput("preRunInit", 64'(initialize), 64'd1);
`endif
      sendByte(hdr[i], gap);
    end
    runAddr = addr & 32'hFFFF_FFFC;
    for (int wi = 0; wi < n; wi++) begin
      w = wordBuf[wi];
      for (int bi = 0; bi < 4; bi++) begin
        b   = w[31 - 8*bi -: 8];
        sum = sum + b;
        if (bi == 3) begin
          e.addr = runAddr;
          e.data = w;
          expQ.push_back(e);
        end
        sendByte(b, gap);
      end
      runAddr = runAddr + 32'd4;
    end
`ifdef LOADER_CHECKSUM_EN
    b = 8'h00 - sum;
    if (badCsum) b = b ^ 8'h01;
    if (n == 0) checkOutput("preRunInit", 64'(initialize), 64'd1);
    sendByte(b, gap);
`else
    if (badCsum) $display("[TB] checksum disabled, badCsum request ignored");
`endif
    in_valid = 1'b0;
  endtask

  task automatic checkRun(input string name);
    checkOutput({name, "_init"}, 64'(initialize), 64'd0);
    checkOutput({name, "_cpuRst"}, 64'(cpu_rst), 64'd0);
    checkOutput({name, "_done"}, 64'(load_done), 64'd1);
    checkOutput({name, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic checkRunSticky(input string name);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      checkOutput({name, "_readyLow"}, 64'(in_ready), 64'd0);
      checkOutput({name, "_doneHeld"}, 64'(load_done), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    checkOutput("rstInit", 64'(initialize), 64'd1);
    checkOutput("rstCpuRst", 64'(cpu_rst), 64'd1);
    checkOutput("rstAddr", 64'(instruction_initialize_address), 64'd0);
    checkOutput("rstData", 64'(instruction_initialize_data), 64'd0);
    checkOutput("rstReady", 64'(in_ready), 64'd0);
    checkOutput("rstDone", 64'(load_done), 64'd0);
    checkOutput("rstError", 64'(load_error), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    wordBuf[0] = 32'h0002_0820;
    wordBuf[1] = 32'h0084_4022;
    applyStimulus(32'h0000_0000, 2, 0, 1'b0);
    wordBuf[0] = 32'h0004_8820;
    applyStimulus(32'h0000_002C, 1, 1, 1'b0);
    checkOutput("initAcrossFrames", 64'(initialize), 64'd1);
    wordBuf[0] = 32'h0800_0003;
    applyStimulus(32'h0000_0103, 1, 0, 1'b0);
    wordBuf[0] = 32'h1122_3344;
    wordBuf[1] = 32'hA5A5_A5A5;
    wordBuf[2] = 32'hDEAD_BEEF;
    applyStimulus(32'hFFFF_FFF8, 3, 0, 1'b0);
    applyStimulus(32'h0000_0000, 0, 0, 1'b0);
    checkRun("run1");
    checkRunSticky("run1");

    resetDut();
    for (int i = 0; i < 6; i++) begin
      sendByte((i == 2 || i == 5) ? 8'h02 : 8'h00, 0);
    end
    sendByte(8'h0B, 0);
    sendByte(8'hAD, 0);
    sendByte(8'hC0, 0);
    expQ.push_back('{addr: 32'h0000_0200, data: 32'h0BAD_C0DE});
    sendByte(8'hDE, 0);
    sendByte(8'h55, 0);
    sendByte(8'h66, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstAddr", 64'(instruction_initialize_address), 64'd0);
    checkOutput("midRstData", 64'(instruction_initialize_data), 64'd0);
    checkOutput("midRstInit", 64'(initialize), 64'd1);
    checkOutput("midRstCpuRst", 64'(cpu_rst), 64'd1);
    checkOutput("midRstReady", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wordBuf[0] = 32'hCAFE_F00D;
    applyStimulus(32'h0000_0040, 1, 0, 1'b0);
    applyStimulus(32'h0000_1234, 0, 2, 1'b0);
    checkRun("run2");

    resetDut();
    applyStimulus(32'h0000_0ABC, 0, 0, 1'b0);
    checkRun("run3");
    checkRunSticky("run3");

`ifdef LOADER_CHECKSUM_EN
    resetDut();
    wordBuf[0] = 32'h1234_5678;
    applyStimulus(32'h0000_0080, 1, 0, 1'b1);
    checkOutput("badCsumError", 64'(load_error), 64'd1);
    checkOutput("badCsumCpuRst", 64'(cpu_rst), 64'd1);
    checkOutput("badCsumInit", 64'(initialize), 64'd1);
    checkOutput("badCsumReady", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("badCsumSticky", 64'(load_error), 64'd1);
    resetDut();
    applyStimulus(32'h0000_0000, 0, 0, 1'b0);
    checkRun("runCsum");
    checkOutput("goodCsumError", 64'(load_error), 64'd0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
